cordic_angle_sequencer: RTL

//  Parametrised CORDIC angle-constant source. On start, streams one elemental

---
 rtl/cordic_angle_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/cordic_angle_sequencer.sv
// cordic_angle_sequencer: streams CORDIC elemental angles and shift indices, one per accepted beat
module cordic_angle_sequencer #(
    parameter int WIDTH      = 20,
    parameter int FRAC       = 15,
    parameter int ITERATIONS = 16,
    parameter int SHIFTW     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  angle,
    output logic [SHIFTW-1:0] shift,
    output logic              last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // floor(atan(2^-i) * 2^30)
    localparam logic [31:0] circ_tbl [32] = '{
        32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
        32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
        32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
        32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
        32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
        32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
        32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000007,
        32'h00000003, 32'h00000001, 32'h00000000, 32'h00000000
    };

    // floor(atanh(2^-i) * 2^30); entry 0 is never emitted
    localparam logic [31:0] hyp_tbl [32] = '{
        32'h00000000, 32'h2327D4F5, 32'h1058AEFA, 32'h080AC48E,
        32'h04015622, 32'h02002AB1, 32'h01000555, 32'h008000AA,
        32'h00400015, 32'h00200002, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
        32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
    };

    state_t      state, state_nx;
    logic        mode_q, rep, hold, accept, start_ok;
    logic [5:0]  cnt;
    logic [4:0]  idx;
    logic [31:0] theta;

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    // next state, handshake and table lookup; angle/shift read zero outside a beat
    always_comb begin
        start_ok  = state == IDLE && start;
        out_valid = state == RUN;
        busy      = state != IDLE;
        done      = state == DONE;
        last      = out_valid && cnt == 6'(ITERATIONS - 1);
        accept    = out_valid && out_ready;
        hold      = mode_q && !rep && (idx == 5'd4 || idx == 5'd13);
        theta     = mode_q ? hyp_tbl[idx] : circ_tbl[idx];
        angle     = out_valid ? WIDTH'(theta >> (30 - FRAC)) : '0;
        shift     = out_valid ? SHIFTW'(idx) : '0;
        state_nx  = start_ok ? RUN : (accept && last) ? DONE : done ? IDLE : state;
    end

    // latched mode, beat counter and shift index; hyperbolic i=4,13 are emitted twice
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mode_q <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            rep    <= 1'b0;
        end else if (start_ok) begin
            mode_q <= mode;
            cnt    <= '0;
            idx    <= {4'b0, mode};
            rep    <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + 6'd1;
            rep <= hold;
            idx <= hold ? idx : idx + 5'd1;
        end
endmodule
